counter_burst_ctrl: RTL and testbench

- Sequencer for the enable-driven up-counter (ports clk / reset_n / en / q).
- On a start command it clears the counter, then issues a programmed number of enable bursts of programmed length, separated by idle gaps.
- Signals completion with a one-cycle done pulse.
- Sits between a host/testbench command interface and the counter's en input; the counter's reset_n stays tied to the system reset.

---
 rtl/counter_burst_ctrl.sv | 164 ++++++++++++++++
 tb/tb_counter_burst_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_burst_ctrl.sv
// counter_burst_ctrl: sequences clear/enable bursts for an enable-driven up-counter.
// A start clears the counter, then issues `repeats` bursts of `run_len` enables
// separated by `gap_len` idle cycles, and finishes with a one-cycle done pulse.
// Optional: define COUNTER_BURST_CTRL_TOTAL_EN to add the 16-bit en_total output.
module counter_burst_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [REP_W-1:0] repeats,
  output logic             busy,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             done,
  output logic [REP_W-1:0] burst_idx
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
  ,
  output logic [15:0]      en_total
`endif
);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_CLR  = 3'd1;
  localparam logic [ST_W-1:0] S_RUN  = 3'd2;
  localparam logic [ST_W-1:0] S_GAP  = 3'd3;
  localparam logic [ST_W-1:0] S_DONE = 3'd4;

  logic [ST_W-1:0]  state_q, state_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  // Shared down-counter: remaining cycles of the current burst or gap.
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] idx_d;
  logic             busy_d, cnt_clr_d, cnt_en_d, done_d;

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    gap_d     = gap_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    idx_d     = burst_idx;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          run_d   = run_len;
          gap_d   = gap_len;
          rep_d   = (repeats == '0) ? REP_W'(1) : repeats;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (run_len == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = run_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == LEN_W'(1)) begin
          if (burst_idx == rep_q - REP_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_q == '0) begin
            // Back-to-back bursts keep the enable continuous.
            cnt_d = run_q;
            idx_d = burst_idx + REP_W'(1);
          end else begin
            cnt_d   = gap_q;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == LEN_W'(1)) begin
          cnt_d   = run_q;
          idx_d   = burst_idx + REP_W'(1);
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort from any active state returns to IDLE, burst_idx frozen.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = burst_idx;
    end

    busy_d    = (state_d != S_IDLE);
    cnt_clr_d = (state_d == S_CLR);
    cnt_en_d  = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // State, latched configuration and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs, each a decode of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_en    <= 1'b0;
      done      <= 1'b0;
      burst_idx <= '0;
    end else begin
      busy      <= busy_d;
      cnt_clr   <= cnt_clr_d;
      cnt_en    <= cnt_en_d;
      done      <= done_d;
      burst_idx <= idx_d;
    end
  end

`ifdef COUNTER_BURST_CTRL_TOTAL_EN
  logic start_ok;
  assign start_ok = (state_q == S_IDLE) && start && !abort;

  // Saturating count of enable cycles since the last accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_total <= '0;
    end else if (start_ok) begin
      en_total <= '0;
    end else if (cnt_en && (en_total != 16'hFFFF)) begin
      en_total <= en_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_burst_ctrl.sv
// Self-checking bench for counter_burst_ctrl: directed scenarios plus randomized
// sequences compared cycle by cycle against an expected-trace model.
module tb_counter_burst_ctrl;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned REP_W = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] gap_len;
  logic [REP_W-1:0] repeats;
  logic             busy;
  logic             cnt_clr;
  logic             cnt_en;
  logic             done;
  logic [REP_W-1:0] burst_idx;
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
  logic [15:0]      en_total;
`endif

  counter_burst_ctrl #(.LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .run_len   (run_len),
    .gap_len   (gap_len),
    .repeats   (repeats),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .done      (done),
    .burst_idx (burst_idx)
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
    ,
    .en_total  (en_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The attached 8-bit up-counter, reset_n tied to system reset.
  logic [7:0] q;
  always @(posedge clk or posedge reset) begin
    if (reset) q <= 8'd0;
    else if (cnt_clr) q <= 8'd0;
    else if (cnt_en) q <= q + 8'd1;
  end

  int total_checks = 0;
  int passed = 0;
  int failed = 0;

  // Expected per-cycle {busy,cnt_clr,cnt_en,done,burst_idx[3:0]} after an accepted start.
  logic [7:0] exp_q[$];
  logic [3:0] last_idx = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pack(input bit b, input bit c, input bit e, input bit d, input int idx);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {b, c, e, d, i4};
  endfunction

  function automatic void build(input int rl, input int gl, input int rp);
    int r;
    exp_q.delete();
    r = (rp == 0) ? 1 : rp;
    if (rl == 0) begin
      exp_q.push_back(pack(1, 0, 0, 1, 0));
      return;
    end
    exp_q.push_back(pack(1, 1, 0, 0, 0));
    for (int b = 0; b < r; b++) begin
      for (int k = 0; k < rl; k++) exp_q.push_back(pack(1, 0, 1, 0, b));
      if (b < r - 1)
        for (int k = 0; k < gl; k++) exp_q.push_back(pack(1, 0, 0, 0, b));
    end
    exp_q.push_back(pack(1, 0, 0, 1, r - 1));
  endfunction

  function automatic logic [7:0] outs();
    return {busy, cnt_clr, cnt_en, done, burst_idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one sequence; optional start re-pulse and abort at given trace indices.
  task automatic run_seq(input string name, input int rl, input int gl, input int rp,
                         input int abort_k, input int restart_k);
    int n;
    int ens;
    build(rl, gl, rp);
    n = exp_q.size();
    ens = 0;
    last_idx = exp_q[n-1][3:0];
    run_len = LEN_W'(rl);
    gap_len = LEN_W'(gl);
    repeats = REP_W'(rp);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_len = LEN_W'($urandom);
    gap_len = LEN_W'($urandom);
    repeats = REP_W'($urandom);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s trace[%0d]", name, i), 32'(outs()), 32'(exp_q[i]));
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
      chk($sformatf("%s en_total[%0d]", name, i), 32'(en_total), 32'(ens));
`endif
      if (exp_q[i][5]) ens++;
      start = (i == restart_k);
      if (i == abort_k) begin
        last_idx = exp_q[i][3:0];
        abort = 1'b1;
        tick();
        abort = 1'b0;
        break;
      end
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s idle", name), 32'(outs()), 32'(pack(0, 0, 0, 0, int'(last_idx))));
    if (rl > 0) chk($sformatf("%s q", name), 32'(q), 32'(ens % 256));
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
    chk($sformatf("%s en_total_end", name), 32'(en_total), 32'(ens));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    run_len = '0;
    gap_len = '0;
    repeats = '0;
    #2;
    chk("reset outputs", 32'(outs()), 32'(0));
    #10;
    reset = 1'b0;
    tick();
    chk("post-reset idle", 32'(outs()), 32'(0));
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
    chk("post-reset en_total", 32'(en_total), 32'(0));
`endif

    // Reset in the middle of a run clears everything asynchronously.
    build(10, 0, 1);
    run_len = 8'd10; gap_len = 8'd0; repeats = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midrun trace[%0d]", i), 32'(outs()), 32'(exp_q[i]));
      tick();
    end
    reset = 1'b1;
    #1;
    chk("async reset outputs", 32'(outs()), 32'(0));
    chk("async reset q", 32'(q), 32'(0));
`ifdef COUNTER_BURST_CTRL_TOTAL_EN
    chk("async reset en_total", 32'(en_total), 32'(0));
`endif
    #2;
    reset = 1'b0;
    tick();
    chk("after reset idle", 32'(outs()), 32'(0));

    run_seq("r5g2x3", 5, 2, 3, -1, -1);
    chk("r5g2x3 q15", 32'(q), 32'(15));
    run_seq("r4g0x2", 4, 0, 2, -1, -1);
    chk("r4g0x2 q8", 32'(q), 32'(8));
    run_seq("r0x7", 0, 3, 7, -1, -1);
    run_seq("r6g3x4 abort", 6, 3, 4, 17, 3);
    chk("abort q12", 32'(q), 32'(12));
    run_seq("rep0", 3, 9, 0, -1, -1);
    chk("rep0 q3", 32'(q), 32'(3));

    // start and abort together in IDLE: nothing starts.
    run_len = 8'd5; gap_len = 8'd1; repeats = 4'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort idle", 32'(outs()), 32'(pack(0, 0, 0, 0, int'(last_idx))));
    tick();
    chk("start+abort still idle", 32'(outs()), 32'(pack(0, 0, 0, 0, int'(last_idx))));

    // Randomized sequences, some aborted.
    for (int t = 0; t < 30; t++) begin
      int rl, gl, rp, ak, n;
      rl = int'($urandom_range(0, 7));
      gl = int'($urandom_range(0, 4));
      rp = int'($urandom_range(0, 5));
      build(rl, gl, rp);
      n = exp_q.size();
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_seq($sformatf("rand%0d", t), rl, gl, rp, ak, -1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end

endmodule
